// File: rtl/bin2seg_pkg.sv
// ============================================================================
// Module   : bin2seg_pkg
// Purpose  : Shared constants, FSM state type and helpers for bin2seg_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin2seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_DASH  = 7'b111_1110;

  // Active-low abcdefg patterns, a in bit 6
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110, 7'b100_1100,
    7'b010_0100, 7'b010_0000, 7'b000_1111, 7'b000_0000, 7'b000_1100
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2seg_seq_nibble_to_seg.sv
// ============================================================================
// Module   : nibble_to_seg
// Purpose  : Combinational BCD nibble to active-low 7-segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_to_seg
  import bin2seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (nibble < 4'd10) begin
      seg = SEG_DIGIT[nibble];
    end
  end

endmodule

`default_nettype wire

// File: rtl/bin2seg_seq.sv
// ============================================================================
// Module   : bin2seg_seq
// Purpose  : Sequential binary to NDIGITS x 7-segment driver (double dabble,
//            one bit per clock). Optional macro LEAD_ZERO_BLANK_EN blanks
//            leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2seg_seq
  import bin2seg_pkg::*;
#(
  parameter int WIDTH   = 7,
  parameter int NDIGITS = 3
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       din,
  output logic                   out_valid,
  output logic                   ovf_o,
  output logic [7*NDIGITS-1:0]   seg_o
);

  localparam int          BCD_W   = 4 * (NDIGITS + 1);
  localparam int          CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [63:0] C_LIMIT = pow10(NDIGITS) - 64'd1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_bin;
  logic [BCD_W-1:0]       r_bcd;
  logic [BCD_W-1:0]       w_bcd_adj;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ovf_cap;
  logic                   w_ovf_cap;
  logic                   r_ovf;
  logic                   r_out_valid;
  logic [7*NDIGITS-1:0]   r_seg;
  logic [7*NDIGITS-1:0]   w_seg_nxt;
  logic [6:0]             w_dig_seg [NDIGITS];

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign ovf_o     = r_ovf;
  assign seg_o     = r_seg;
  assign w_ovf_cap = 64'(din) > C_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i <= NDIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  generate
    for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
      nibble_to_seg u_nibble_to_seg (
        .nibble (r_bcd[4*k +: 4]),
        .seg    (w_dig_seg[k])
      );
    end
  endgenerate

  always_comb begin
    logic w_all_zero;
    w_seg_nxt  = '0;
    w_all_zero = 1'b1;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      w_seg_nxt[7*k +: 7] = w_dig_seg[k];
`ifdef LEAD_ZERO_BLANK_EN
      w_all_zero = w_all_zero && (r_bcd[4*k +: 4] == 4'd0);
      if (w_all_zero && (k >= 1)) begin
        w_seg_nxt[7*k +: 7] = SEG_BLANK;
      end
`endif
      if (r_ovf_cap) begin
        w_seg_nxt[7*k +: 7] = SEG_DASH;
      end
    end
    w_all_zero = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_ovf_cap   <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_seg       <= {NDIGITS{SEG_BLANK}};
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bin     <= din;
            r_bcd     <= '0;
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_ovf_cap <= w_ovf_cap;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt - 1'b1;
        end
        DONE: begin
          r_seg       <= w_seg_nxt;
          r_ovf       <= r_ovf_cap;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2seg_seq.sv
// ============================================================================
// Module   : tb_bin2seg_seq
// Purpose  : Directed self-checking bench for bin2seg_seq (3-digit, 2-digit
//            and 1-bit/1-digit instances). Honours LEAD_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2seg_seq;

  localparam logic [6:0] S0 = 7'b000_0001;
  localparam logic [6:0] S1 = 7'b100_1111;
  localparam logic [6:0] S2 = 7'b001_0010;
  localparam logic [6:0] S3 = 7'b000_0110;
  localparam logic [6:0] S4 = 7'b100_1100;
  localparam logic [6:0] S5 = 7'b010_0100;
  localparam logic [6:0] S6 = 7'b010_0000;
  localparam logic [6:0] S7 = 7'b000_1111;
  localparam logic [6:0] S9 = 7'b000_1100;
  localparam logic [6:0] SB = 7'b111_1111;
  localparam logic [6:0] SD = 7'b111_1110;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] SZ = SB;
`else
  localparam logic [6:0] SZ = S0;
`endif

  logic        clk;
  logic        rst_n;
  logic [6:0]  din7;
  logic [0:0]  din1;
  logic        iv3, iv2, iv1;
  logic        rdy3, rdy2, rdy1;
  logic        ov3, ov2, ov1;
  logic        ovf3, ovf2, ovf1;
  logic [20:0] seg3;
  logic [13:0] seg2;
  logic [6:0]  seg1;

  int n_checks;
  int n_errors;

  bin2seg_seq #(.WIDTH(7), .NDIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(rdy3), .din(din7),
    .out_valid(ov3), .ovf_o(ovf3), .seg_o(seg3)
  );

  bin2seg_seq #(.WIDTH(7), .NDIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2), .din(din7),
    .out_valid(ov2), .ovf_o(ovf2), .seg_o(seg2)
  );

  bin2seg_seq #(.WIDTH(1), .NDIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .din(din1),
    .out_valid(ov1), .ovf_o(ovf1), .seg_o(seg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_ov(input int which);
    case (which)
      3:       return ov3;
      2:       return ov2;
      default: return ov1;
    endcase
  endfunction

  function automatic logic cur_rdy(input int which);
    case (which)
      3:       return rdy3;
      2:       return rdy2;
      default: return rdy1;
    endcase
  endfunction

  // One conversion on the chosen instance; lat = edges from accept to out_valid
  task automatic run(input int which, input logic [6:0] v,
                     output logic [20:0] seg, output logic ovf, output int lat);
    @(negedge clk);
    chk("in_ready_before", 64'(cur_rdy(which)), 64'd1);
    din7 = v;
    din1 = v[0:0];
    iv3  = (which == 3);
    iv2  = (which == 2);
    iv1  = (which == 1);
    @(posedge clk);
    #1;
    iv3 = 1'b0; iv2 = 1'b0; iv1 = 1'b0;
    lat = 0;
    while (!cur_ov(which) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    case (which)
      3:       begin seg = seg3;          ovf = ovf3; end
      2:       begin seg = 21'(seg2);     ovf = ovf2; end
      default: begin seg = 21'(seg1);     ovf = ovf1; end
    endcase
    @(posedge clk);
    #1;
    chk("out_valid_one_cycle", 64'(cur_ov(which)), 64'd0);
  endtask

  initial begin
    logic [20:0] seg;
    logic        ovf;
    int          lat;
    int          pulses;
    int          t_first, t_second;
    logic [20:0] seg_first, seg_second;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    din7 = '0; din1 = '0;
    iv3 = 1'b0; iv2 = 1'b0; iv1 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_seg3", 64'(seg3), 64'h1F_FFFF);
    chk("rst_ready3", 64'(rdy3), 64'd1);
    chk("rst_valid3", 64'(ov3), 64'd0);
    chk("rst_ovf3", 64'(ovf3), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ov3) pulses++;
    end
    chk("idle_no_valid", 64'(pulses), 64'd0);
    chk("idle_seg3", 64'(seg3), 64'h1F_FFFF);

    // Max value, latency
    run(3, 7'd127, seg, ovf, lat);
    chk("lat_127", 64'(lat), 64'd8);
    chk("seg_127", 64'(seg), 64'({S1, S2, S7}));
    chk("ovf_127", 64'(ovf), 64'd0);

    // Zero and leading-zero handling
    run(3, 7'd0, seg, ovf, lat);
    chk("seg_000", 64'(seg), 64'({SZ, SZ, S0}));
    run(3, 7'd5, seg, ovf, lat);
    chk("seg_005", 64'(seg), 64'({SZ, SZ, S5}));
    run(3, 7'd105, seg, ovf, lat);
    chk("seg_105", 64'(seg), 64'({S1, S0, S5}));

    // Back-to-back with in_valid held high
    @(negedge clk);
    din7 = 7'd42;
    iv3  = 1'b1;
    @(posedge clk);
    #1;
    din7 = 7'd13;
    pulses = 0; t_first = -1; t_second = -1;
    seg_first = '0; seg_second = '0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (ov3) begin
        pulses++;
        if (pulses == 1) begin t_first = c; seg_first = seg3; end
        if (pulses == 2) begin t_second = c; seg_second = seg3; iv3 = 1'b0; end
      end
      if (c == 3) din7 = 7'd99;
      if (c == 5) din7 = 7'd13;
    end
    iv3 = 1'b0;
    chk("b2b_pulses", 64'(pulses), 64'd2);
    chk("b2b_t_first", 64'(t_first), 64'd8);
    chk("b2b_t_second", 64'(t_second), 64'd17);
    chk("b2b_seg_42", 64'(seg_first), 64'({SZ, S4, S2}));
    chk("b2b_seg_13", 64'(seg_second), 64'({SZ, S1, S3}));

    // Two-digit overflow
    run(2, 7'd100, seg, ovf, lat);
    chk("ovf_100", 64'(ovf), 64'd1);
    chk("seg_100", 64'(seg), 64'({SD, SD}));
    run(2, 7'd99, seg, ovf, lat);
    chk("ovf_99", 64'(ovf), 64'd0);
    chk("seg_99", 64'(seg), 64'({S9, S9}));
    run(2, 7'd7, seg, ovf, lat);
    chk("seg2_07", 64'(seg), 64'({SZ, S7}));
    run(2, 7'd127, seg, ovf, lat);
    chk("ovf2_127", 64'(ovf), 64'd1);
    chk("seg2_127", 64'(seg), 64'({SD, SD}));

    // Single-bit, single-digit instance
    run(1, 7'd1, seg, ovf, lat);
    chk("w1_lat", 64'(lat), 64'd2);
    chk("w1_seg_1", 64'(seg), 64'(S1));
    run(1, 7'd0, seg, ovf, lat);
    chk("w1_seg_0", 64'(seg), 64'(S0));

    // Abort mid-conversion via reset
    @(negedge clk);
    din7 = 7'd99;
    iv3  = 1'b1;
    @(posedge clk);
    #1;
    iv3 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_seg3", 64'(seg3), 64'h1F_FFFF);
    chk("abort_seg2", 64'(seg2), 64'h3FFF);
    chk("abort_ovf2", 64'(ovf2), 64'd0);
    chk("abort_ready3", 64'(rdy3), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov3) pulses++;
    end
    chk("abort_no_valid", 64'(pulses), 64'd0);
    run(3, 7'd64, seg, ovf, lat);
    chk("lat_064", 64'(lat), 64'd8);
    chk("seg_064", 64'(seg), 64'({SZ, S6, S4}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
